// File: rtl/systolic_skew_feeder_if.sv
// Column-vector handshake and skewed PE-array operand bus for systolic_skew_feeder.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4
);
    logic                       clr;
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_data;
    logic                       in_last;
    logic [ROWS*DATA_WIDTH-1:0] skew_data;
    logic [ROWS-1:0]            skew_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output clr, in_valid, in_data, in_last,
        input  in_ready, skew_data, skew_valid, busy, done
    );

    modport slave (
        input  clr, in_valid, in_data, in_last,
        output in_ready, skew_data, skew_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews column vectors across ROWS lanes (lane r delayed r+1 cycles) to feed a systolic PE array.
// Accepts in IDLE/FEED; in_ready drops from the last beat until done, so matrices never overlap.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q;
    logic             accept;

    // live_q keeps in_ready low while in reset and until the first edge after release.
    assign bus.in_ready = live_q && ((state_q == S_IDLE) || (state_q == S_FEED));
    assign accept       = bus.in_valid && bus.in_ready && !bus.clr;
    assign bus.busy     = (state_q == S_FEED) || (state_q == S_FLUSH);
    assign bus.done     = (state_q == S_DONE) && !bus.clr;

    // FLUSH exits when the counter would reach 0 so DONE lines up with the final
    // operand on row ROWS-1; with ROWS=1 the counter starts at 0 and FLUSH is one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_FEED: begin
                    if (accept) begin
                        if (bus.in_last) begin
                            state_d = S_FLUSH;
                            cnt_d   = CNT_W'(ROWS - 1);
                        end else begin
                            state_d = S_FEED;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [r+1];
        logic                  vld_q [r+1];

        // Idle cycles push a zero/invalid bubble so unused lane slots read as 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) begin
                    dat_q[k] <= '0;
                    vld_q[k] <= 1'b0;
                end
            end else if (bus.clr) begin
                for (int k = 0; k <= r; k++) begin
                    dat_q[k] <= '0;
                    vld_q[k] <= 1'b0;
                end
            end else begin
                dat_q[0] <= accept ? bus.in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                vld_q[0] <= accept;
                for (int k = 1; k <= r; k++) begin
                    dat_q[k] <= dat_q[k-1];
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        assign bus.skew_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
        assign bus.skew_valid[r]                         = vld_q[r];
    end
endmodule
